alu_result_reg: RTL and testbench

- Registered result/flag stage directly downstream of the ALU output mux. It consumes the selected 8-bit result (mux out_8) and the 4-bit NZVC flags (mux out_4).
- Holds the architectural accumulator and the NZVC flag register.
- Merges incoming flags under a per-bit update mask.
- Forwards each accepted result plus its merged flags to the next consumer through a 2-entry valid/ready buffer, so backpressure never loses an ALU result.

---
 rtl/alu_result_reg.sv | 104 ++++++++++
 tb/tb_alu_result_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_result_reg.sv
// alu_result_reg: registered result/flag stage behind the ALU output mux.
// Holds the accumulator and NZVC flag register, merges new flags under a
// per-bit mask, and forwards each accepted {result, merged flags} pair
// through a 2-entry valid/ready FIFO so downstream stalls never drop a result.
module alu_result_reg #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] res_in,
  input  logic [FLAG_W-1:0] nzvc_in,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              flag_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res_out,
  output logic [FLAG_W-1:0] nzvc_out,
  output logic [DATA_W-1:0] acc,
  output logic [FLAG_W-1:0] flags,
  output logic [1:0]        count
);

  // Storage is two entries, so a single pointer bit wraps 1->0 naturally.
  logic [DEPTH-1:0][DATA_W-1:0] mem_res_q, mem_res_d;
  logic [DEPTH-1:0][FLAG_W-1:0] mem_flg_q, mem_flg_d;
  logic                         head_q, head_d;
  logic                         tail_q, tail_d;
  logic [1:0]                   count_q, count_d;
  logic [DATA_W-1:0]            acc_q, acc_d;
  logic [FLAG_W-1:0]            flags_q, flags_d;

  logic              push, pop;
  logic [FLAG_W-1:0] base, merged;

  // Handshakes and flag merge; in_ready depends on registered count only.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    base      = flag_clr ? '0 : flags_q;
    merged    = (base & ~flag_mask) | (nzvc_in & flag_mask);
  end

  // Next-state for accumulator, flags and FIFO bookkeeping.
  always_comb begin
    acc_d     = acc_q;
    flags_d   = flags_q;
    mem_res_d = mem_res_q;
    mem_flg_d = mem_flg_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (push) begin
      acc_d             = res_in;
      flags_d           = merged;
      mem_res_d[tail_q] = res_in;
      mem_flg_d[tail_q] = merged;
      tail_d            = tail_q + 1'b1;
    end else if (flag_clr) begin
      flags_d = '0;
    end
    if (pop) head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards buffered entries and wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      flags_q   <= '0;
      mem_res_q <= '0;
      mem_flg_q <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      mem_res_q <= mem_res_d;
      mem_flg_q <= mem_flg_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Head slot is only rewritten when the FIFO is empty, so the outputs stay
  // stable under backpressure and hold the last popped pair when empty.
  assign res_out  = mem_res_q[head_q];
  assign nzvc_out = mem_flg_q[head_q];
  assign acc      = acc_q;
  assign flags    = flags_q;
  assign count    = count_q;

endmodule

// File: tb/tb_alu_result_reg.sv
// Bench for alu_result_reg: directed test-plan sequences plus a random phase.
// A reference model tracks acc/flags/occupancy and pushes expected outputs into
// a scoreboard queue; a separate monitor pops and checks on every handshake.
module tb_alu_result_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] res_in;
  logic [3:0] nzvc_in, flag_mask;
  logic       flag_clr;
  logic       out_valid, out_ready;
  logic [7:0] res_out, acc;
  logic [3:0] nzvc_out, flags;
  logic [1:0] count;

  int pass_cnt = 0;
  int total    = 0;

  alu_result_reg #(.DATA_W(8), .FLAG_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .res_in(res_in), .nzvc_in(nzvc_in), .flag_mask(flag_mask), .flag_clr(flag_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_out(res_out), .nzvc_out(nzvc_out),
    .acc(acc), .flags(flags), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state.
  logic [11:0] sb[$];   // expected {res, flags} in output order (monitor pops)
  int          m_occ;   // model buffer occupancy
  logic [7:0]  m_acc;
  logic [3:0]  m_flags;
  bit          chk_en = 0;

  // Model: compare architectural state, then advance it by the upcoming edge.
  always @(negedge clk) begin
    bit m_push, m_pop;
    logic [3:0] b, mg;
    if (chk_en) begin
      check("acc", acc, m_acc);
      check("flags", flags, m_flags);
      check("count", count, m_occ);
      check("in_ready", in_ready, m_occ < 2);
      check("out_valid", out_valid, m_occ > 0);
    end
    if (rst) begin
      m_acc = 0; m_flags = 0; m_occ = 0;
      sb.delete();
      chk_en = 1;
    end else begin
      m_push = in_valid && (m_occ < 2);
      m_pop  = (m_occ > 0) && out_ready;
      b  = flag_clr ? 4'h0 : m_flags;
      mg = (b & ~flag_mask) | (nzvc_in & flag_mask);
      if (m_push) begin
        m_acc = res_in; m_flags = mg;
        sb.push_back({res_in, mg});
      end else if (flag_clr) m_flags = 0;
      m_occ = m_occ + int'(m_push) - int'(m_pop);
    end
  end

  // Monitor: each accepted output must match the oldest expected entry.
  always @(negedge clk) begin
    logic [11:0] e;
    if (chk_en && !rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("res_out", res_out, e[11:4]);
        check("nzvc_out", nzvc_out, e[3:0]);
      end
    end
  end

  // Drive one cycle of inputs, just after the rising edge.
  task automatic cyc(input bit iv, input logic [7:0] r, input logic [3:0] n,
                     input logic [3:0] m, input bit c, input bit ordy);
    in_valid = iv; res_in = r; nzvc_in = n; flag_mask = m;
    flag_clr = c; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; res_in = 0; nzvc_in = 0; flag_mask = 0;
    flag_clr = 0; out_ready = 0;
    @(posedge clk); #1;
    // 1: reset with in_valid high must not push
    rst = 1; cyc(1, 8'h77, 4'hF, 4'hF, 0, 0);
    rst = 0;
    check("in_ready_after_rst", in_ready, 1);
    check("count_after_rst", count, 0);
    // 2: single transfer
    cyc(1, 8'hAA, 4'b1100, 4'hF, 0, 1);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    // 3: mask merge, then with clear
    cyc(1, 8'h11, 4'b0011, 4'b0001, 0, 1);
    check("merge_flags", flags, 4'b1101);
    cyc(1, 8'h22, 4'b0011, 4'b0001, 1, 1);
    check("clr_merge_flags", flags, 4'b0001);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    // 4: backpressure
    cyc(1, 8'h55, 4'h1, 4'hF, 0, 0);
    cyc(1, 8'h0F, 4'h2, 4'hF, 0, 0);
    check("full_in_ready", in_ready, 0);
    cyc(1, 8'hEE, 4'h3, 4'hF, 0, 0);
    check("bp_acc", acc, 8'h0F);
    cyc(1, 8'hEE, 4'h3, 4'hF, 0, 1);
    check("ready_after_pop", in_ready, 1);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    // 5: back-to-back push/pop across pointer wrap
    for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 4'(i), 4'hF, 0, 1);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    // 6: reset while full; stale entries must never appear
    cyc(1, 8'hC1, 4'h5, 4'hF, 0, 0);
    cyc(1, 8'hC2, 4'h6, 4'hF, 0, 0);
    check("full_before_rst", count, 2);
    rst = 1; cyc(0, 8'h00, 4'h0, 4'h0, 1, 1);
    rst = 0;
    check("rst_count", count, 0);
    check("rst_acc", acc, 0);
    cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    // Random phase
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      cyc($urandom_range(0, 99) < 60, 8'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 4'h0, 4'h0, 0, 1);
    check("drain_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
